spart_tx: RTL and testbench



---
 rtl/spart_tx.sv | 177 +++++++++++++++++
 tb/tb_spart_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_tx.sv
// spart_tx: transmit half of the SPART.
// Decodes driver writes to the tx buffer and baud divisor, runs a free-running
// baud-tick generator and serializes buffered bytes onto txd, LSB first.
// Optional build macro: SPART_TX_PARITY_EN inserts an even-parity bit between
// data bit 7 and the stop bit (8E1 instead of 8N1).
//
// state  | meaning
// IDLE   | line high, waiting for a tick with the buffer full
// START  | start bit (txd = 0)
// DATA   | data bits, LSB first, bit_idx counts 0..7
// PARITY | even parity of the byte (only with SPART_TX_PARITY_EN)
// STOP   | stop bit (txd = 1); may chain straight into START
module spart_tx #(
    parameter logic [15:0] DEFAULT_DIV = 16'd5207
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] databus,
    output logic       txd,
    output logic       tbr,
    output logic       tx_busy
);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state;
    logic [15:0] div_reg;
    logic [15:0] div_new;
    logic [15:0] baud_cnt;
    logic        tick;
    logic        bus_wr;
    logic        buf_wr;
    logic        div_lo_wr;
    logic        div_hi_wr;
    logic [7:0]  buf_data;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
`ifdef SPART_TX_PARITY_EN
    logic        par_bit;
`endif

    assign bus_wr    = iocs && !iorw;
    assign buf_wr    = bus_wr && (ioaddr == 2'b00);
    assign div_lo_wr = bus_wr && (ioaddr == 2'b10);
    assign div_hi_wr = bus_wr && (ioaddr == 2'b11);
    assign tick      = (baud_cnt == 16'd0);

    // Merge the written byte into the divisor so the counter can reload the full new value.
    always_comb begin
        div_new = div_reg;
        if (div_lo_wr) div_new[7:0]  = databus;
        if (div_hi_wr) div_new[15:8] = databus;
    end

    // Divisor register, updated a byte at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= DEFAULT_DIV;
        end else if (div_lo_wr || div_hi_wr) begin
            div_reg <= div_new;
        end
    end

    // Free-running baud down-counter; a divisor write restarts the current bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= DEFAULT_DIV;
        end else if (div_lo_wr || div_hi_wr) begin
            baud_cnt <= div_new;
        end else if (tick) begin
            baud_cnt <= div_reg;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    // Tx buffer, frame FSM and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tbr      <= 1'b1;
            tx_busy  <= 1'b0;
            buf_data <= 8'h00;
            shift    <= 8'h00;
            bit_idx  <= 3'd0;
`ifdef SPART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            // Writes are judged against registered tbr; a load on the same edge
            // only happens when tbr is 0, so the two never collide.
            if (buf_wr && tbr) begin
                buf_data <= databus;
                tbr      <= 1'b0;
            end
            case (state)
                IDLE: begin
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tick && !tbr) begin
                        shift   <= buf_data;
                        tbr     <= 1'b1;
                        state   <= START;
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
`ifdef SPART_TX_PARITY_EN
                        par_bit <= ^buf_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= 3'd0;
                        txd     <= shift[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= par_bit;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            txd <= shift[1];
                        end
                    end
                end
`ifdef SPART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (!tbr) begin
                            shift   <= buf_data;
                            tbr     <= 1'b1;
                            state   <= START;
                            txd     <= 1'b0;
`ifdef SPART_TX_PARITY_EN
                            par_bit <= ^buf_data;
`endif
                        end else begin
                            state   <= IDLE;
                            txd     <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: directed bench for spart_tx. The serial line is captured every
// cycle into queues and the frames are then compared bit by bit.
module tb_spart_tx;

`ifdef SPART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus;
    logic       txd;
    logic       tbr;
    logic       tx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic cap_en = 1'b0;
    logic cap_txd[$];
    logic cap_tbr[$];
    logic cap_busy[$];

    spart_tx #(.DEFAULT_DIV(16'd5207)) dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .txd     (txd),
        .tbr     (tbr),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the line once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (cap_en) begin
            cap_txd.push_back(txd);
            cap_tbr.push_back(tbr);
            cap_busy.push_back(tx_busy);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; databus = d;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1; databus = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_write(2'b10, d[7:0]);
        bus_write(2'b11, d[15:8]);
    endtask

    task automatic cap_start();
        @(posedge clk);
        cap_en = 1'b0;
        cap_txd.delete();
        cap_tbr.delete();
        cap_busy.delete();
        cap_en = 1'b1;
    endtask

    task automatic cap_stop();
        @(posedge clk);
        cap_en = 1'b0;
    endtask

    function automatic int find_start(input int from);
        for (int i = from; i < cap_txd.size(); i++) begin
            if (cap_txd[i] == 1'b0 && (i == 0 || cap_txd[i-1] == 1'b1)) return i;
        end
        return -1;
    endfunction

    task automatic check_frame(input string tag, input int s, input logic [7:0] b, input int hold);
        logic [10:0] bits;
        logic [31:0] got;
        logic [31:0] exp;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef SPART_TX_PARITY_EN
        bits[9]  = ^b;
        bits[10] = 1'b1;
`else
        bits[9]  = 1'b1;
`endif
        check({tag, "_len"}, (cap_txd.size() >= s + FB * hold) ? 1 : 0, 1);
        for (int k = 0; k < FB; k++) begin
            got = '0;
            for (int h = 0; h < hold; h++) begin
                if (s + k * hold + h < cap_txd.size()) got[h] = cap_txd[s + k * hold + h];
            end
            exp = bits[k] ? ((32'd1 << hold) - 32'd1) : 32'd0;
            check($sformatf("%s_bit%0d", tag, k), got, exp);
        end
    endtask

    initial begin
        int s;
        int s2;
        int zeros;
        rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00; databus = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and 20 idle cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            check("rst_txd", txd, 1);
            check("rst_tbr", tbr, 1);
            check("rst_busy", tx_busy, 0);
            @(negedge clk);
        end

        // Reads and status-address writes do not touch the buffer.
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; databus = 8'h42;
        @(negedge clk);
        iocs = 1'b0;
        check("read_ignored_tbr", tbr, 1);
        bus_write(2'b01, 8'h42);
        check("addr01_ignored_tbr", tbr, 1);

        // Single frame 0xA5 at divisor 3.
        do_reset();
        set_div(16'd3);
        cap_start();
        bus_write(2'b00, 8'hA5);
        check("a5_tbr_low", tbr, 0);
        repeat (70) @(negedge clk);
        cap_stop();
        s = find_start(0);
        check("a5_found", (s >= 1) ? 1 : 0, 1);
        if (s < 1) s = 1;
        check_frame("a5", s, 8'hA5, 4);
        check("a5_tbr_before", cap_tbr[s-1], 0);
        check("a5_tbr_at_start", cap_tbr[s], 1);
        check("a5_busy_start", cap_busy[s], 1);
        check("a5_busy_last", cap_busy[s + FB*4 - 1], 1);
        check("a5_busy_after", cap_busy[s + FB*4], 0);
        check("a5_idle_after", cap_txd[s + FB*4], 1);

        // Back-to-back frames 0x00 then 0xFF with no idle gap.
        do_reset();
        set_div(16'd3);
        cap_start();
        bus_write(2'b00, 8'h00);
        begin
            int n;
            n = 0;
            while (tbr == 1'b0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_tbr_return", tbr, 1);
        end
        bus_write(2'b00, 8'hFF);
        check("b2b_tbr_low", tbr, 0);
        repeat (110) @(negedge clk);
        cap_stop();
        s = find_start(0);
        check("b2b_found", (s >= 0) ? 1 : 0, 1);
        if (s < 0) s = 0;
        check_frame("b2b_f1", s, 8'h00, 4);
        check_frame("b2b_f2", s + FB*4, 8'hFF, 4);
        check("b2b_busy_gap", cap_busy[s + FB*4], 1);
        check("b2b_idle_after", cap_txd[s + FB*8], 1);
        check("b2b_busy_after", cap_busy[s + FB*8], 0);

        // Write while buffer full is dropped (lands on the load edge).
        do_reset();
        set_div(16'd3);
        cap_start();
        bus_write(2'b00, 8'h3C);
        bus_write(2'b00, 8'h99);
        repeat (100) @(negedge clk);
        cap_stop();
        s = find_start(0);
        check("drop_found", (s >= 0) ? 1 : 0, 1);
        if (s < 0) s = 0;
        check_frame("drop_3c", s, 8'h3C, 4);
        s2 = find_start(s + FB*4);
        check("drop_no_second", s2, -1);
        check("drop_busy_after", cap_busy[s + FB*4], 0);

        // Divisor 0: one-cycle bits.
        do_reset();
        set_div(16'd0);
        cap_start();
        bus_write(2'b00, 8'h5A);
        repeat (30) @(negedge clk);
        cap_stop();
        s = find_start(0);
        check("div0_found", (s >= 0) ? 1 : 0, 1);
        if (s < 0) s = 0;
        check_frame("div0", s, 8'h5A, 1);
        check("div0_idle_after", cap_txd[s + FB], 1);

        // Reset during data bit 4 of 0x0F with 0x55 pending.
        do_reset();
        set_div(16'd3);
        bus_write(2'b00, 8'h0F);
        begin
            int n;
            n = 0;
            while (txd == 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("rst_mid_start_seen", txd, 0);
        end
        repeat (2) @(negedge clk);
        bus_write(2'b00, 8'h55);
        repeat (17) @(negedge clk);
        check("rst_mid_bit4", txd, 0);
        check("rst_mid_pending", tbr, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_txd", txd, 1);
        check("rst_mid_tbr", tbr, 1);
        check("rst_mid_busy", tx_busy, 0);
        set_div(16'd3);
        zeros = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (txd == 1'b0 || tx_busy == 1'b1) zeros++;
        end
        check("rst_mid_no_frame", zeros, 0);

`ifdef SPART_TX_PARITY_EN
        // Parity frames: 0x07 has parity 1, 0x03 has parity 0.
        do_reset();
        set_div(16'd3);
        cap_start();
        bus_write(2'b00, 8'h07);
        repeat (70) @(negedge clk);
        bus_write(2'b00, 8'h03);
        repeat (70) @(negedge clk);
        cap_stop();
        s = find_start(0);
        check("par07_found", (s >= 0) ? 1 : 0, 1);
        if (s < 0) s = 0;
        check_frame("par07", s, 8'h07, 4);
        check("par07_pbit", cap_txd[s + 9*4], 1);
        s2 = find_start(s + FB*4);
        check("par03_found", (s2 >= 0) ? 1 : 0, 1);
        if (s2 < 0) s2 = 0;
        check_frame("par03", s2, 8'h03, 4);
        check("par03_pbit", cap_txd[s2 + 9*4], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
